switch_cell_pack: RTL and testbench

Ingress cell packer that sits directly upstream of the switch core's input cell FIFOs. It takes one frame at a time from the ingress frame stream and prepends a 128-bit header word. It then writes the header and the frame's 128-bit data words into the core data FIFO, zero-pads to a whole number of 4-word cells, and only then writes the 16-bit cell pointer descriptor into the core pointer FIFO. The core reads its data FIFO without an empty check, so the pointer-after-data ordering is mandatory.

---
 rtl/switch_cell_pack.sv | 176 +++++++++++++++++
 tb/tb_switch_cell_pack.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_cell_pack.sv
// Ingress cell packer: prepends a header word, writes frame data padded to whole
// 4-word cells into the core data FIFO, then writes the cell pointer descriptor.
module switch_cell_pack #(
   parameter logic [3:0] SRC_PORT = 4'd0
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [127:0] in_data,
   input  logic         in_valid,
   input  logic         in_sop,
   input  logic         in_eop,
   input  logic [10:0]  in_len,
   input  logic [3:0]   in_portmap,
   output logic         in_ready,
   output logic [127:0] i_cell_data_fifo_din,
   output logic         i_cell_data_fifo_wr,
   output logic [15:0]  i_cell_ptr_fifo_din,
   output logic         i_cell_ptr_fifo_wr,
   input  logic         i_cell_bp,
   output logic [15:0]  pkt_cnt,
   output logic [15:0]  drop_cnt
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_DATA    = 3'd1;
   localparam logic [2:0] S_PAD     = 3'd2;
   localparam logic [2:0] S_PTR     = 3'd3;
   localparam logic [2:0] S_DISCARD = 3'd4;

   logic [2:0]   state_q, state_d;
   logic [3:0]   portmap_q, portmap_d;
   logic [7:0]   t_q, t_d;
   logic [7:0]   rd_q, rd_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         over_q, over_d;
   logic [127:0] ddin_q, ddin_d;
   logic         dwr_q, dwr_d;
   logic [15:0]  pdin_q, pdin_d;
   logic         pwr_q, pwr_d;
   logic [15:0]  pkt_cnt_q, pkt_cnt_d;
   logic [15:0]  drop_cnt_q, drop_cnt_d;

   logic [7:0]   d_words;
   logic [7:0]   t_words;
   logic         accept;

   // D = ceil(len/16); T = (1 + D) rounded up to a multiple of 4
   assign d_words = 8'(({1'b0, in_len} + 12'd15) >> 4);
   assign t_words = (d_words + 8'd4) & 8'hFC;
   assign accept  = in_valid && in_ready;

   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         S_IDLE:    in_ready = !in_sop;
         S_DATA:    in_ready = !i_cell_bp;
         S_DISCARD: in_ready = 1'b1;
         default:   in_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      portmap_d  = portmap_q;
      t_d        = t_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      over_d     = over_q;
      ddin_d     = ddin_q;
      dwr_d      = 1'b0;
      pdin_d     = pdin_q;
      pwr_d      = 1'b0;
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_sop) begin
               if (in_len == 11'd0) begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
                  over_d     = 1'b0;
                  state_d    = S_DISCARD;
               end else if (!i_cell_bp) begin
                  portmap_d = in_portmap;
                  t_d       = t_words;
                  rd_d      = d_words;
                  cnt_d     = 8'd1;
                  ddin_d    = {109'd0, SRC_PORT, in_portmap, in_len};
                  dwr_d     = 1'b1;
                  state_d   = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               ddin_d = in_data;
               dwr_d  = 1'b1;
               cnt_d  = cnt_q + 8'd1;
               rd_d   = rd_q - 8'd1;
               if (rd_q == 8'd1) begin
                  if (in_eop) begin
                     state_d = (cnt_q + 8'd1 == t_q) ? S_PTR : S_PAD;
                  end else begin
                     over_d  = 1'b1;
                     state_d = S_DISCARD;
                  end
               end else if (in_eop) begin
                  // short frame: missing data words are zero-filled by PAD
                  state_d = S_PAD;
               end
            end
         end
         S_PAD: begin
            ddin_d = 128'd0;
            dwr_d  = 1'b1;
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == t_q) begin
               state_d = S_PTR;
            end
         end
         S_PTR: begin
            pdin_d    = {4'b0000, portmap_q, t_q};
            pwr_d     = 1'b1;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            state_d   = S_IDLE;
         end
         S_DISCARD: begin
            if (accept && in_eop) begin
               if (over_q) begin
                  state_d = (cnt_q == t_q) ? S_PTR : S_PAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         portmap_q  <= 4'd0;
         t_q        <= 8'd0;
         rd_q       <= 8'd0;
         cnt_q      <= 8'd0;
         over_q     <= 1'b0;
         ddin_q     <= 128'd0;
         dwr_q      <= 1'b0;
         pdin_q     <= 16'd0;
         pwr_q      <= 1'b0;
         pkt_cnt_q  <= 16'd0;
         drop_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         portmap_q  <= portmap_d;
         t_q        <= t_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         over_q     <= over_d;
         ddin_q     <= ddin_d;
         dwr_q      <= dwr_d;
         pdin_q     <= pdin_d;
         pwr_q      <= pwr_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign i_cell_data_fifo_din = ddin_q;
   assign i_cell_data_fifo_wr  = dwr_q;
   assign i_cell_ptr_fifo_din  = pdin_q;
   assign i_cell_ptr_fifo_wr   = pwr_q;
   assign pkt_cnt              = pkt_cnt_q;
   assign drop_cnt             = drop_cnt_q;

endmodule

// File: tb/tb_switch_cell_pack.sv
// Bench for switch_cell_pack: per-frame expected write lists from length arithmetic,
// checked against every data/pointer strobe, plus literal descriptor pins.
module tb_switch_cell_pack;

   localparam logic [3:0] SRC = 4'd5;

   logic         clk;
   logic         rstn;
   logic [127:0] in_data;
   logic         in_valid;
   logic         in_sop;
   logic         in_eop;
   logic [10:0]  in_len;
   logic [3:0]   in_portmap;
   logic         in_ready;
   logic [127:0] ddin;
   logic         dwr;
   logic [15:0]  pdin;
   logic         pwr;
   logic         bp;
   logic [15:0]  pkt_cnt;
   logic [15:0]  drop_cnt;

   switch_cell_pack #(.SRC_PORT(SRC)) dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .in_data              (in_data),
      .in_valid             (in_valid),
      .in_sop               (in_sop),
      .in_eop               (in_eop),
      .in_len               (in_len),
      .in_portmap           (in_portmap),
      .in_ready             (in_ready),
      .i_cell_data_fifo_din (ddin),
      .i_cell_data_fifo_wr  (dwr),
      .i_cell_ptr_fifo_din  (pdin),
      .i_cell_ptr_fifo_wr   (pwr),
      .i_cell_bp            (bp),
      .pkt_cnt              (pkt_cnt),
      .drop_cnt             (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [127:0] exp_data[$];
   logic [15:0]  exp_ptr[$];
   logic [15:0]  exp_e;
   logic [15:0]  last_ptr = 16'd0;
   int wr_since_ptr = 0;
   int exp_pkt = 0;
   int exp_drop = 0;
   int frame_no = 0;
   bit bp_toggle = 0;
   bit bp_rand = 0;
   bit gaps = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Backpressure driver
   initial begin
      bp = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bp_toggle) bp = ~bp;
         else if (bp_rand) bp = ($urandom % 3 == 0);
         else bp = 1'b0;
      end
   end

   // Compare process: every strobe is checked against the expected write lists
   always @(negedge clk) begin
      if (rstn) begin
         if (pwr) begin
            chk("ptr_data_overlap", 128'(dwr), 128'd0);
            if (exp_ptr.size() == 0) begin
               chk("ptr_extra", 128'(pwr), 128'd0);
            end else begin
               exp_e = exp_ptr.pop_front();
               chk("ptr_desc", 128'(pdin), 128'(exp_e));
               chk("ptr_data_count", 128'(wr_since_ptr), 128'(exp_e[7:0]));
            end
            wr_since_ptr = 0;
            last_ptr = pdin;
         end
         if (dwr) begin
            if (exp_data.size() == 0) chk("data_extra", 128'(dwr), 128'd0);
            else chk("data_word", ddin, exp_data.pop_front());
            wr_since_ptr++;
         end
      end
   end

   task automatic drive_word(input logic [127:0] d, input logic sop, input logic eop,
                             input logic [10:0] len, input logic [3:0] pm);
      int n = 0;
      bit acc = 0;
      in_data = d; in_sop = sop; in_eop = eop; in_len = len; in_portmap = pm;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 4000);
      chk("handshake", 128'(acc), 128'd1);
      in_valid = 1'b0;
      in_sop = 1'b0;
      in_eop = 1'b0;
      if (gaps && ($urandom % 4 == 0)) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int len, input logic [3:0] pm, input int nw);
      int d = (len + 15) / 16;
      int t = ((d + 1 + 3) / 4) * 4;
      logic [127:0] w[$];
      logic [127:0] hdr;
      for (int i = 0; i < nw; i++) w.push_back({$urandom, $urandom, $urandom, $urandom});
      if (len == 0) begin
         exp_drop++;
      end else begin
         hdr = 128'(len) | (128'(pm) << 11) | (128'(SRC) << 15);
         exp_data.push_back(hdr);
         for (int i = 0; i < d; i++) exp_data.push_back(i < nw ? w[i] : 128'd0);
         for (int i = 1 + d; i < t; i++) exp_data.push_back(128'd0);
         exp_ptr.push_back({4'b0000, pm, 8'(t)});
         exp_pkt++;
      end
      $display("frame %0d: len=%0d portmap=%h words=%0d D=%0d T=%0d", frame_no, len, pm, nw, d, t);
      frame_no++;
      for (int i = 0; i < nw; i++) drive_word(w[i], i == 0, i == nw - 1, 11'(len), pm);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_data.size() != 0 || exp_ptr.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain", 128'(exp_data.size() + exp_ptr.size()), 128'd0);
   endtask

   initial begin
      #900000;
      total++;
      bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      rstn = 1'b0;
      in_data = '0; in_valid = 1'b0; in_sop = 1'b1; in_eop = 1'b0;
      in_len = '0; in_portmap = '0;
      #12;
      chk("rst_ready_sop", 128'(in_ready), 128'd0);
      in_sop = 1'b0;
      #1;
      chk("rst_ready_nosop", 128'(in_ready), 128'd1);
      chk("rst_dwr", 128'(dwr), 128'd0);
      chk("rst_pwr", 128'(pwr), 128'd0);
      chk("rst_ddin", ddin, 128'd0);
      chk("rst_pdin", 128'(pdin), 128'd0);
      chk("rst_pkt", 128'(pkt_cnt), 128'd0);
      chk("rst_drop", 128'(drop_cnt), 128'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      send_frame(64, 4'b0010, 4);
      drain();
      chk("pin_64B_desc", 128'(last_ptr), 128'h0208);
      chk("pin_64B_pkt", 128'(pkt_cnt), 128'd1);

      send_frame(1518, 4'hA, 95);
      drain();
      chk("pin_1518_desc", 128'(last_ptr), 128'h0A60);

      send_frame(40, 4'h3, 2);
      drain();
      chk("pin_short_desc", 128'(last_ptr), 128'h0304);

      send_frame(16, 4'h1, 5);
      drain();
      chk("pin_long_desc", 128'(last_ptr), 128'h0104);
      send_frame(100, 4'h0, 7);
      drain();

      bp_toggle = 1;
      send_frame(300, 4'hF, 19);
      drain();
      bp_toggle = 0;
      chk("pin_bp_desc", 128'(last_ptr), 128'h0F14);

      drive_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 11'd0, 4'd0);
      send_frame(0, 4'h6, 2);
      drain();
      chk("pin_zero_drop", 128'(drop_cnt), 128'd1);
      chk("pin_zero_pkt", 128'(pkt_cnt), 128'd6);

      bp_rand = 1;
      gaps = 1;
      for (int f = 0; f < 30; f++) begin
         int len = $urandom_range(1, 1518);
         int d = (len + 15) / 16;
         int r = $urandom % 8;
         int nw = d;
         if ($urandom % 5 == 0)
            drive_word({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 11'd0, 4'd0);
         if (r == 0) begin
            len = 0;
            nw = $urandom_range(1, 3);
         end else if (r == 1) begin
            nw = $urandom_range(1, d);
         end else if (r == 2) begin
            nw = d + $urandom_range(1, 3);
         end
         send_frame(len, 4'($urandom), nw);
      end
      drain();
      bp_rand = 0;
      gaps = 0;
      chk("final_pkt", 128'(pkt_cnt), 128'(16'(exp_pkt)));
      chk("final_drop", 128'(drop_cnt), 128'(16'(exp_drop)));

      // Reset mid-frame: header plus two accepted copies of the held word
      @(posedge clk);
      #1;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_sop = 1'b1; in_eop = 1'b0; in_len = 11'd800; in_portmap = 4'h1; in_valid = 1'b1;
      exp_data.push_back(128'(800) | (128'(4'h1) << 11) | (128'(SRC) << 15));
      exp_data.push_back(in_data);
      exp_data.push_back(in_data);
      repeat (4) @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("midrst_ready", 128'(in_ready), 128'd0);
      chk("midrst_dwr", 128'(dwr), 128'd0);
      chk("midrst_pwr", 128'(pwr), 128'd0);
      chk("midrst_ddin", ddin, 128'd0);
      chk("midrst_pkt", 128'(pkt_cnt), 128'd0);
      chk("midrst_drop", 128'(drop_cnt), 128'd0);
      chk("midrst_consumed", 128'(exp_data.size()), 128'd0);
      exp_data.delete();
      exp_ptr.delete();
      wr_since_ptr = 0;
      in_valid = 1'b0;
      in_sop = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_pkt", 128'(pkt_cnt), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
